// File: rtl/reduce_sched_pkg.sv
// Shared types and defaults for the reduce-sum frame scheduler.
package reduce_sched_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, WAIT_RES} state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int FRAME_LEN_DEF = 256;
  localparam int DATA_W_DEF    = 32;
  localparam int TIMEOUT_DEF   = 1024;

  localparam int ID_W  = $clog2(NUM_REQ_DEF);
  localparam int CNT_W = $clog2(FRAME_LEN_DEF);

  // Counter width that stays legal for degenerate sizes.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reduce_frame_sched_rr_arbiter.sv
// Combinational round-robin pick: first valid requester strictly after ptr, wrapping.
module rr_arbiter
  import reduce_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt_oh,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] idx;

  // Walk from the farthest offset down so the nearest valid requester wins last.
  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        gnt_oh      = '0;
        gnt_oh[idx] = 1'b1;
        gnt_id      = idx;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reduce_frame_sched.sv
// Frame scheduler sharing one reduce-sum engine between NUM_REQ requesters.
// Optional WAIT_RES watchdog is enabled by defining REDUCE_SCHED_TIMEOUT_EN.
module reduce_frame_sched
  import reduce_sched_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       eng_clr,
  output logic                       eng_valid,
  output logic [DATA_W-1:0]          eng_data,
  input  logic                       eng_done,
  input  logic [DATA_W-1:0]          eng_sum,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_W-1:0]          res_data,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic                       res_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_LEN);

  state_e              state_q, state_d;
  logic [IW-1:0]       gnt_q, gnt_d, rr_q, rr_d;
  logic [NUM_REQ-1:0]  gnt_oh_q, gnt_oh_d;
  logic [CW-1:0]       count_q, count_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [IW-1:0]       res_id_q, res_id_d;

  logic [NUM_REQ-1:0]  arb_oh;
  logic [IW-1:0]       arb_id;
  logic                arb_any;
  logic [DATA_W-1:0]   lane_data [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane_data[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .ptr       (rr_q),
    .gnt_oh    (arb_oh),
    .gnt_id    (arb_id),
    .any       (arb_any)
  );

`ifdef REDUCE_SCHED_TIMEOUT_EN
  localparam int WD_W = width_of(TIMEOUT);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            res_err_q, res_err_d;

  assign wd_d    = (state_q == WAIT_RES) ? wd_q + 1'b1 : '0;
  assign res_err = res_err_q;
`else
  // The watchdog limit has no effect in this build.
  localparam int unused_timeout = TIMEOUT;
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_oh_d    = gnt_oh_q;
    rr_d        = rr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
`ifdef REDUCE_SCHED_TIMEOUT_EN
    res_err_d   = res_err_q;
`endif
    eng_clr     = 1'b0;
    eng_valid   = 1'b0;
    eng_data    = '0;
    req_ready   = '0;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Granting while the held result is being accepted this cycle is allowed.
        if (arb_any && (!res_valid_q || res_ready)) begin
          gnt_d    = arb_id;
          gnt_oh_d = arb_oh;
          rr_d     = arb_id;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        eng_clr = 1'b1;
        count_d = '0;
        state_d = STREAM;
      end
      STREAM: begin
        req_ready = gnt_oh_q;
        eng_valid = req_valid[gnt_q];
        eng_data  = lane_data[gnt_q];
        if (eng_valid) begin
          if (count_q == CW'(FRAME_LEN - 1)) begin
            count_d = '0;
            state_d = WAIT_RES;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      WAIT_RES: begin
        if (eng_done) begin
          res_valid_d = 1'b1;
          res_data_d  = eng_sum;
          res_id_d    = gnt_q;
`ifdef REDUCE_SCHED_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
          state_d     = IDLE;
        end
`ifdef REDUCE_SCHED_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          res_valid_d = 1'b1;
          res_data_d  = '0;
          res_id_d    = gnt_q;
          res_err_d   = 1'b1;
          eng_clr     = 1'b1;
          state_d     = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_oh_q    <= '0;
      rr_q        <= IW'(NUM_REQ - 1);
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
`ifdef REDUCE_SCHED_TIMEOUT_EN
      res_err_q   <= 1'b0;
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_oh_q    <= gnt_oh_d;
      rr_q        <= rr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
`ifdef REDUCE_SCHED_TIMEOUT_EN
      res_err_q   <= res_err_d;
      wd_q        <= wd_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_reduce_frame_sched.sv
// Directed bench for reduce_frame_sched with a small reduce-sum engine model (FRAME_LEN=4).
module tb_reduce_frame_sched;
  import reduce_sched_pkg::*;

  localparam int NR = 4;
  localparam int FL = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              eng_clr, eng_valid, eng_done;
  logic [DW-1:0]     eng_data, eng_sum;
  logic              res_valid, res_ready, res_err;
  logic [DW-1:0]     res_data;
  logic [ID_W-1:0]   res_id;

  always #5 clk = ~clk;

  reduce_frame_sched #(.NUM_REQ(NR), .FRAME_LEN(FL), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_clr(eng_clr), .eng_valid(eng_valid), .eng_data(eng_data),
    .eng_done(eng_done), .eng_sum(eng_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_err(res_err)
  );

  // Reduce-sum engine: accumulates FL elements, answers eng_lat cycles later.
  logic [DW-1:0] acc;
  int n_el, dly;
  int eng_lat = 2;
  bit done_en = 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0; n_el <= 0; dly <= 0; eng_done <= 1'b0; eng_sum <= '0;
    end else begin
      eng_done <= 1'b0;
      if (eng_clr) begin
        acc <= '0; n_el <= 0; dly <= 0;
      end else if (eng_valid) begin
        acc  <= acc + eng_data;
        n_el <= n_el + 1;
        if (n_el == FL - 1) dly <= eng_lat;
      end else if (dly > 0) begin
        dly <= dly - 1;
        if (dly == 1 && done_en) begin
          eng_done <= 1'b1;
          eng_sum  <= acc;
        end
      end
    end
  end

  typedef struct { int id; int data; int err; } res_t;
  res_t rq[$];
  int   gq[$];
  int   idx[NR], rem[NR], xfer_cnt[NR];
  bit   bub[NR];
  bit   phase;
  int   clr_cnt, viol, gap_cnt, checks, errors;
  logic [NR-1:0] prev_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_lanes();
    for (int r = 0; r < NR; r++) begin
      req_data[r*DW +: DW] = DW'(r*100 + idx[r] + 1);
      req_valid[r] = (rem[r] > 0) && (!bub[r] || phase);
    end
  endtask

  // One clock: called at a negedge, samples and logs, advances lanes, returns at next negedge.
  task automatic tick();
    logic [NR-1:0] hs;
    logic [DW-1:0] exp_d;
    res_t t;
    hs = req_valid & req_ready;
    exp_d = '0;
    for (int r = 0; r < NR; r++) if (hs[r]) exp_d = DW'(r*100 + idx[r] + 1);
    chk("eng_valid", 64'(eng_valid), 64'(|hs));
    if (eng_valid) chk("eng_data", 64'(eng_data), 64'(exp_d));
    if ($countones(req_ready) > 1) viol++;
    if (eng_clr) clr_cnt++;
    if ((req_ready & ~req_valid) != 0) gap_cnt++;
    if (req_ready != 0 && prev_ready == 0)
      for (int r = 0; r < NR; r++) if (req_ready[r]) gq.push_back(r);
    prev_ready = req_ready;
    if (res_valid && res_ready) begin
      t.id = int'(res_id); t.data = int'(res_data); t.err = int'(res_err);
      rq.push_back(t);
      $display("result id=%0d data=%0d err=%0d", t.id, t.data, t.err);
    end
    for (int r = 0; r < NR; r++) if (hs[r]) xfer_cnt[r]++;
    @(posedge clk); #1;
    for (int r = 0; r < NR; r++) if (hs[r]) begin idx[r]++; rem[r]--; end
    phase = ~phase;
    drive_lanes();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_clr"}, 64'(eng_clr), 64'(0));
    chk({tag, "_evalid"}, 64'(eng_valid), 64'(0));
    chk({tag, "_edata"}, 64'(eng_data), 64'(0));
    chk({tag, "_rvalid"}, 64'(res_valid), 64'(0));
    chk({tag, "_rdata"}, 64'(res_data), 64'(0));
    chk({tag, "_rid"}, 64'(res_id), 64'(0));
    chk({tag, "_rerr"}, 64'(res_err), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k, n0;
    int exp_id[6], exp_sum[6];
    exp_id  = '{1, 3, 0, 1, 3, 0};
    exp_sum = '{410, 1210, 10, 426, 1226, 26};
    checks = 0; errors = 0; clr_cnt = 0; viol = 0; gap_cnt = 0;
    prev_ready = '0; phase = 1'b0;
    for (int r = 0; r < NR; r++) begin idx[r] = 0; rem[r] = 0; bub[r] = 0; xfer_cnt[r] = 0; end
    rst_n = 1'b0; res_ready = 1'b0;
    drive_lanes();
    repeat (2) @(negedge clk);
    chk_quiet("reset");

    // Release with only requester 0 valid: CLEAR, then STREAM for requester 0.
    rem[0] = 100; drive_lanes();
    rst_n = 1'b1;
    tick();
    chk("first_clr", 64'(eng_clr), 64'(1));
    chk("first_clr_ready", 64'(req_ready), 64'(0));
    tick();
    chk("first_stream_ready", 64'(req_ready), 64'(4'b0001));
    tick(); tick();

    // Asynchronous reset mid-frame.
    rst_n = 1'b0; #1;
    chk_quiet("midreset");
    @(negedge clk);
    idx[0] = 0; rem[0] = 4; drive_lanes();
    rst_n = 1'b1;

    // Single frame 1,2,3,4 -> 10, held until accepted.
    tick();
    chk("t2_clr", 64'(eng_clr), 64'(1));
    k = 0;
    while (!res_valid && k < 40) begin tick(); k++; end
    chk("t2_res_valid", 64'(res_valid), 64'(1));
    chk("t2_res_data", 64'(res_data), 64'(10));
    chk("t2_res_id", 64'(res_id), 64'(0));
    chk("t2_res_err", 64'(res_err), 64'(0));
    repeat (3) begin
      tick();
      chk("t2_hold_valid", 64'(res_valid), 64'(1));
      chk("t2_hold_data", 64'(res_data), 64'(10));
    end
    res_ready = 1'b1;
    tick();
    chk("t2_accepted", 64'(res_valid), 64'(0));

    // Round-robin over requesters 0,1,3, two frames each.
    rq.delete(); gq.delete(); clr_cnt = 0; viol = 0;
    for (int r = 0; r < NR; r++) idx[r] = 0;
    rem[0] = 8; rem[1] = 8; rem[3] = 8; drive_lanes();
    k = 0;
    while (rq.size() < 6 && k < 400) begin tick(); k++; end
    chk("t3_results", 64'(rq.size()), 64'(6));
    chk("t3_grants", 64'(gq.size()), 64'(6));
    if (rq.size() == 6 && gq.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("t3_grant_order", 64'(gq[i]), 64'(exp_id[i]));
        chk("t3_res_id", 64'(rq[i].id), 64'(exp_id[i]));
        chk("t3_res_data", 64'(rq[i].data), 64'(exp_sum[i]));
        chk("t3_res_err", 64'(rq[i].err), 64'(0));
      end
    end
    chk("t3_clr_count", 64'(clr_cnt), 64'(6));
    chk("t3_onehot", 64'(viol), 64'(0));

    // Backpressure: result held, requester 1 pending, then same-cycle accept and grant.
    rq.delete(); gq.delete();
    for (int r = 0; r < NR; r++) idx[r] = 0;
    res_ready = 1'b0; rem[0] = 4; drive_lanes();
    k = 0;
    while (!req_ready[0] && k < 20) begin tick(); k++; end
    chk("t4_grant0", 64'(req_ready), 64'(4'b0001));
    rem[1] = 4; drive_lanes();
    k = 0;
    while (!res_valid && k < 40) begin tick(); k++; end
    chk("t4_res_data", 64'(res_data), 64'(10));
    chk("t4_res_id", 64'(res_id), 64'(0));
    clr_cnt = 0;
    repeat (4) tick();
    chk("t4_no_clr", 64'(clr_cnt), 64'(0));
    chk("t4_idle_ready", 64'(req_ready), 64'(0));
    chk("t4_held", 64'(res_valid), 64'(1));
    res_ready = 1'b1;
    tick();
    chk("t4_accept", 64'(res_valid), 64'(0));
    chk("t4_grant_clr", 64'(eng_clr), 64'(1));
    tick();
    chk("t4_grant1", 64'(req_ready), 64'(4'b0010));
    k = 0;
    while (rq.size() < 2 && k < 40) begin tick(); k++; end
    chk("t4_results", 64'(rq.size()), 64'(2));
    if (rq.size() == 2) begin
      chk("t4_first_data", 64'(rq[0].data), 64'(10));
      chk("t4_second_id", 64'(rq[1].id), 64'(1));
      chk("t4_second_data", 64'(rq[1].data), 64'(410));
    end

    // Bubbles on requester 2: valid every other cycle.
    rq.delete(); gap_cnt = 0;
    for (int r = 0; r < NR; r++) begin idx[r] = 0; xfer_cnt[r] = 0; end
    bub[2] = 1'b1; rem[2] = 4; drive_lanes();
    k = 0;
    while (rq.size() < 1 && k < 80) begin tick(); k++; end
    chk("t5_results", 64'(rq.size()), 64'(1));
    chk("t5_xfers", 64'(xfer_cnt[2]), 64'(4));
    chk("t5_gaps_seen", 64'(gap_cnt >= 3), 64'(1));
    if (rq.size() == 1) begin
      chk("t5_res_id", 64'(rq[0].id), 64'(2));
      chk("t5_res_data", 64'(rq[0].data), 64'(810));
    end
    bub[2] = 1'b0;

`ifdef REDUCE_SCHED_TIMEOUT_EN
    // Watchdog: no eng_done -> error result on WAIT_RES cycle 8.
    done_en = 1'b0; idx[3] = 0; rem[3] = 4; drive_lanes();
    k = 0;
    while (rem[3] > 0 && k < 30) begin tick(); k++; end
    k = 1;
    while (!eng_clr && k < 40) begin tick(); k++; end
    chk("t6_timeout_cycle", 64'(k), 64'(8));
    tick();
    chk("t6_err_valid", 64'(res_valid), 64'(1));
    chk("t6_err_flag", 64'(res_err), 64'(1));
    chk("t6_err_data", 64'(res_data), 64'(0));
    chk("t6_err_id", 64'(res_id), 64'(3));
    tick();
    // eng_done on the timeout cycle wins.
    done_en = 1'b1; eng_lat = 7; idx[3] = 0; rem[3] = 4; drive_lanes();
    k = 0;
    while (rem[3] > 0 && k < 30) begin tick(); k++; end
    k = 1;
    while (!eng_done && k < 40) begin tick(); k++; end
    chk("t6_done_cycle", 64'(k), 64'(8));
    chk("t6_done_no_clr", 64'(eng_clr), 64'(0));
    tick();
    chk("t6_ok_valid", 64'(res_valid), 64'(1));
    chk("t6_ok_err", 64'(res_err), 64'(0));
    chk("t6_ok_data", 64'(res_data), 64'(1210));
    chk("t6_ok_id", 64'(res_id), 64'(3));
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
